// File: rtl/stack_alu_ctrl.sv
// Operand-stack controller that sequences an external combinational ALU.
// Single-cycle stack commands complete in IDLE; arithmetic waits ALU_CICLI cycles for the ALU.
module stack_alu_ctrl #(
  parameter int unsigned N         = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOG_DEPTH = 3,
  parameter int unsigned ALU_CICLI = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [N-1:0]         dato_in,
  output logic                 cmd_ready,
  output logic [N-1:0]         alu_x,
  output logic [N-1:0]         alu_y,
  output logic [2:0]           alu_alpha,
  input  logic [N-1:0]         alu_z,
  input  logic                 alu_segno,
  output logic [N-1:0]         top,
  output logic [LOG_DEPTH:0]   sp,
  output logic                 done,
  output logic [1:0]           errore,
  output logic                 segno
);

  localparam int unsigned CntW = (ALU_CICLI > 1) ? $clog2(ALU_CICLI) : 1;
  localparam logic [LOG_DEPTH:0] SpFull = (LOG_DEPTH + 1)'(DEPTH);

  localparam logic [2:0] CmdPush  = 3'd0;
  localparam logic [2:0] CmdPop   = 3'd1;
  localparam logic [2:0] CmdAdd   = 3'd2;
  localparam logic [2:0] CmdSub   = 3'd3;
  localparam logic [2:0] CmdInc   = 3'd4;
  localparam logic [2:0] CmdDec   = 3'd5;
  localparam logic [2:0] CmdDiv   = 3'd6;
  localparam logic [2:0] CmdClear = 3'd7;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluInc = 3'd2;
  localparam logic [2:0] AluDec = 3'd3;
  localparam logic [2:0] AluDiv = 3'd6;

  localparam logic [1:0] ErrOk    = 2'd0;
  localparam logic [1:0] ErrUnder = 2'd1;
  localparam logic [1:0] ErrOver  = 2'd2;
  localparam logic [1:0] ErrDivZ  = 2'd3;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [LOG_DEPTH:0]  r_sp, w_sp_d;
  logic                r_done, w_done_d;
  logic [1:0]          r_err, w_err_d;
  logic                r_segno, w_segno_d;
  logic [N-1:0]        r_x, w_x_d;
  logic [N-1:0]        r_y, w_y_d;
  logic [2:0]          r_alpha, w_alpha_d;
  logic                r_binop, w_binop_d;
  logic [N-1:0]        r_stack [DEPTH];

  logic                 w_we;
  logic [LOG_DEPTH-1:0] w_waddr;
  logic [N-1:0]         w_wdata;
  logic [LOG_DEPTH-1:0] w_tidx;
  logic [LOG_DEPTH-1:0] w_sidx;
  logic [N-1:0]         w_t;
  logic [N-1:0]         w_s;
  logic                 w_sp_ge1;
  logic                 w_sp_ge2;

  // Low bits of sp wrap correctly at sp==DEPTH, so T/S indices never need the MSB.
  assign w_tidx   = r_sp[LOG_DEPTH-1:0] - LOG_DEPTH'(1);
  assign w_sidx   = r_sp[LOG_DEPTH-1:0] - LOG_DEPTH'(2);
  assign w_t      = r_stack[w_tidx];
  assign w_s      = r_stack[w_sidx];
  assign w_sp_ge1 = (r_sp != '0);
  assign w_sp_ge2 = (r_sp > (LOG_DEPTH + 1)'(1));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sp_d    = r_sp;
    w_done_d  = 1'b0;
    w_err_d   = r_err;
    w_segno_d = r_segno;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_alpha_d = r_alpha;
    w_binop_d = r_binop;
    w_we      = 1'b0;
    w_waddr   = w_tidx;
    w_wdata   = alu_z;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          unique case (cmd)
            CmdPush: begin
              w_done_d = 1'b1;
              if (r_sp == SpFull) begin
                w_err_d = ErrOver;
              end else begin
                w_err_d = ErrOk;
                w_we    = 1'b1;
                w_waddr = r_sp[LOG_DEPTH-1:0];
                w_wdata = dato_in;
                w_sp_d  = r_sp + (LOG_DEPTH + 1)'(1);
              end
            end
            CmdPop: begin
              w_done_d = 1'b1;
              if (!w_sp_ge1) begin
                w_err_d = ErrUnder;
              end else begin
                w_err_d = ErrOk;
                w_sp_d  = r_sp - (LOG_DEPTH + 1)'(1);
              end
            end
            CmdClear: begin
              w_done_d = 1'b1;
              w_err_d  = ErrOk;
              w_sp_d   = '0;
            end
            CmdAdd, CmdSub, CmdDiv: begin
              if (!w_sp_ge2) begin
                w_done_d = 1'b1;
                w_err_d  = ErrUnder;
              end else if (cmd == CmdDiv && w_t == '0) begin
                w_done_d = 1'b1;
                w_err_d  = ErrDivZ;
              end else begin
                w_x_d     = w_s;
                w_y_d     = w_t;
                w_alpha_d = (cmd == CmdAdd) ? AluAdd : (cmd == CmdSub) ? AluSub : AluDiv;
                w_binop_d = 1'b1;
                w_cnt_d   = CntW'(ALU_CICLI - 1);
                w_state_d = StWait;
              end
            end
            CmdInc, CmdDec: begin
              if (!w_sp_ge1) begin
                w_done_d = 1'b1;
                w_err_d  = ErrUnder;
              end else begin
                w_x_d     = w_t;
                w_y_d     = '0;
                w_alpha_d = (cmd == CmdInc) ? AluInc : AluDec;
                w_binop_d = 1'b0;
                w_cnt_d   = CntW'(ALU_CICLI - 1);
                w_state_d = StWait;
              end
            end
            default: ;
          endcase
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_we      = 1'b1;
          w_waddr   = r_binop ? w_sidx : w_tidx;
          w_sp_d    = r_binop ? (r_sp - (LOG_DEPTH + 1)'(1)) : r_sp;
          w_segno_d = alu_segno;
          w_done_d  = 1'b1;
          w_err_d   = ErrOk;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_sp    <= '0;
      r_done  <= 1'b0;
      r_err   <= ErrOk;
      r_segno <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_alpha <= '0;
      r_binop <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_sp    <= w_sp_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_segno <= w_segno_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_alpha <= w_alpha_d;
      r_binop <= w_binop_d;
      if (w_we) begin
        r_stack[w_waddr] <= w_wdata;
      end
    end
  end

  assign cmd_ready = (r_state == StIdle);
  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_alpha = r_alpha;
  assign top       = w_sp_ge1 ? w_t : '0;
  assign sp        = r_sp;
  assign done      = r_done;
  assign errore    = r_err;
  assign segno     = r_segno;

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Bench for stack_alu_ctrl: queue-based stack model checked every cycle, plus directed
// sequences with hand-computed literal expectations.
module tb_stack_alu_ctrl;

  localparam int unsigned N         = 32;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned LOG_DEPTH = 3;
  localparam int unsigned ALU_CICLI = 2;

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] INC = 3'd4, DEC = 3'd5, DIV = 3'd6, CLEAR = 3'd7;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [2:0]         cmd = 3'd0;
  logic [N-1:0]       dato_in = '0;
  logic               cmd_ready;
  logic [N-1:0]       alu_x, alu_y, alu_z;
  logic [2:0]         alu_alpha;
  logic               alu_segno;
  logic [N-1:0]       top;
  logic [LOG_DEPTH:0] sp;
  logic               done;
  logic [1:0]         errore;
  logic               segno;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  stack_alu_ctrl #(
    .N(N), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .ALU_CICLI(ALU_CICLI)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .dato_in(dato_in),
    .cmd_ready(cmd_ready), .alu_x(alu_x), .alu_y(alu_y), .alu_alpha(alu_alpha),
    .alu_z(alu_z), .alu_segno(alu_segno), .top(top), .sp(sp), .done(done),
    .errore(errore), .segno(segno)
  );

  always #5 clock = ~clock;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    case (alu_alpha)
      3'd0:    alu_z = alu_x + alu_y;
      3'd1:    alu_z = alu_x - alu_y;
      3'd2:    alu_z = alu_x + 1;
      3'd3:    alu_z = alu_x - 1;
      3'd6:    alu_z = (alu_y == '0) ? '1 : alu_x / alu_y;
      default: alu_z = '0;
    endcase
  end
  assign alu_segno = alu_z[N-1];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: stack as a queue, ALU results computed when a command is accepted.
  logic [N-1:0] q[$];
  int           cyc = 0;
  int           m_done_at = 0;
  bit           m_busy = 0, m_done = 0, m_bin = 0, m_segno = 0;
  logic [1:0]   m_err = 0;
  logic [2:0]   m_alpha = 0;
  logic [N-1:0] m_res = 0, m_x = 0, m_y = 0, m_t, m_s;
  int           m_n;

  task automatic fin(input logic [1:0] e);
    m_done = 1;
    m_err  = e;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_busy = 0; m_done = 0; m_err = 0; m_segno = 0;
      m_x = 0; m_y = 0; m_alpha = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (m_busy) begin
        if (cyc == m_done_at) begin
          q.delete(q.size() - 1);
          if (m_bin) q.delete(q.size() - 1);
          q.push_back(m_res);
          m_segno = m_res[N-1];
          m_busy  = 0;
          fin(2'd0);
        end
      end else if (cmd_valid) begin
        m_n = q.size();
        m_t = (m_n > 0) ? q[m_n-1] : '0;
        m_s = (m_n > 1) ? q[m_n-2] : '0;
        case (cmd)
          PUSH:  if (m_n == int'(DEPTH)) fin(2'd2); else begin q.push_back(dato_in); fin(2'd0); end
          POP:   if (m_n < 1) fin(2'd1); else begin q.delete(m_n - 1); fin(2'd0); end
          CLEAR: begin q.delete(); fin(2'd0); end
          ADD, SUB, DIV: begin
            if (m_n < 2) fin(2'd1);
            else if (cmd == DIV && m_t == '0) fin(2'd3);
            else begin
              m_x = m_s; m_y = m_t; m_bin = 1;
              m_alpha = (cmd == ADD) ? 3'd0 : (cmd == SUB) ? 3'd1 : 3'd6;
              m_res = (cmd == ADD) ? m_s + m_t : (cmd == SUB) ? m_s - m_t : m_s / m_t;
              m_busy = 1; m_done_at = cyc + int'(ALU_CICLI);
            end
          end
          default: begin
            if (m_n < 1) fin(2'd1);
            else begin
              m_x = m_t; m_y = '0; m_bin = 0;
              m_alpha = (cmd == INC) ? 3'd2 : 3'd3;
              m_res = (cmd == INC) ? m_t + 1 : m_t - 1;
              m_busy = 1; m_done_at = cyc + int'(ALU_CICLI);
            end
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("sp", 32'(sp), 32'(q.size()));
      chk("top", top, (q.size() > 0) ? q[q.size()-1] : '0);
      chk("done", 32'(done), 32'(m_done));
      if (m_done) chk("errore", 32'(errore), 32'(m_err));
      chk("segno", 32'(segno), 32'(m_segno));
      chk("alu_x", alu_x, m_x);
      chk("alu_y", alu_y, m_y);
      chk("alu_alpha", 32'(alu_alpha), 32'(m_alpha));
    end
  end

  task automatic start(input logic [2:0] c, input logic [N-1:0] d);
    @(negedge clock);
    cmd_valid = 1; cmd = c; dato_in = d;
    @(negedge clock);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clock);
    tests++;
    if (m_busy) begin
      fails++;
      $display("FAIL wait_idle: still busy after 20 cycles, expected idle");
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [N-1:0] d);
    start(c, d);
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 0;
    chk_en = 1;
    chk("rst_sp", 32'(sp), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_top", top, 0);

    issue(PUSH, 5); issue(PUSH, 3);
    start(ADD, 0);
    chk("add_wait_ready", 32'(cmd_ready), 0);
    chk("add_wait_alpha", 32'(alu_alpha), 0);
    chk("add_wait_x", alu_x, 5);
    chk("add_wait_y", alu_y, 3);
    chk("add_wait_done", 32'(done), 0);
    @(negedge clock);
    chk("add_wait2_done", 32'(done), 0);
    @(negedge clock);
    chk("add_done", 32'(done), 1);
    chk("add_err", 32'(errore), 0);
    chk("add_top", top, 8);
    chk("add_sp", 32'(sp), 1);
    chk("add_segno", 32'(segno), 0);

    issue(CLEAR, 0); issue(PUSH, 3); issue(PUSH, 5); issue(SUB, 0);
    chk("sub_top", top, 32'hFFFF_FFFE);
    chk("sub_segno", 32'(segno), 1);
    chk("sub_sp", 32'(sp), 1);
    issue(INC, 0);
    chk("inc1_top", top, 32'hFFFF_FFFF);
    issue(INC, 0);
    chk("inc2_top", top, 0);
    chk("inc2_segno", 32'(segno), 0);

    issue(CLEAR, 0); issue(PUSH, 7); issue(PUSH, 0); issue(DIV, 0);
    chk("divz_done", 32'(done), 1);
    chk("divz_err", 32'(errore), 3);
    chk("divz_sp", 32'(sp), 2);
    chk("divz_top", top, 0);
    issue(POP, 0); issue(PUSH, 2); issue(DIV, 0);
    chk("div_top", top, 3);
    chk("div_sp", 32'(sp), 1);

    issue(CLEAR, 0); issue(POP, 0);
    chk("pop_under_err", 32'(errore), 1);
    chk("pop_under_sp", 32'(sp), 0);
    issue(PUSH, 1); issue(ADD, 0);
    chk("add_under_err", 32'(errore), 1);
    chk("add_under_top", top, 1);
    issue(CLEAR, 0);
    for (int i = 0; i < int'(DEPTH); i++) issue(PUSH, 32'(10 + i));
    issue(PUSH, 99);
    chk("ovf_err", 32'(errore), 2);
    chk("ovf_sp", 32'(sp), DEPTH);
    chk("ovf_top", top, 17);
    issue(DEC, 0);
    chk("dec_full_top", top, 16);

    issue(CLEAR, 0);
    @(negedge clock);
    cmd_valid = 1; cmd = PUSH; dato_in = 1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clock);
      chk("b2b_done", 32'(done), 1);
      dato_in = 32'(i);
      if (i == 4) cmd_valid = 0;
    end
    chk("b2b_sp", 32'(sp), 3);
    chk("b2b_top", top, 3);

    @(negedge clock);
    cmd_valid = 1; cmd = ADD;
    @(negedge clock);
    cmd = PUSH; dato_in = 9;
    chk("held_ready", 32'(cmd_ready), 0);
    wait_idle();
    chk("held_add_done", 32'(done), 1);
    chk("held_add_top", top, 5);
    @(negedge clock);
    cmd_valid = 0;
    chk("held_push_done", 32'(done), 1);
    chk("held_sp", 32'(sp), 3);
    chk("held_top", top, 9);

    issue(CLEAR, 0); issue(PUSH, 4); issue(PUSH, 6);
    start(ADD, 0);
    #2 reset = 1;
    #1;
    chk("rstw_sp", 32'(sp), 0);
    chk("rstw_done", 32'(done), 0);
    chk("rstw_segno", 32'(segno), 0);
    chk("rstw_top", top, 0);
    @(negedge clock);
    #2 reset = 0;
    @(negedge clock);
    chk("rstw_ready", 32'(cmd_ready), 1);
    chk("rstw_sp_after", 32'(sp), 0);
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
